// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch: fetch stage of the nandgame CPU.
//
// Owns the program counter and issues one read at a time to instruction
// memory. A fetched word is held for the decoder until execute accepts it.
// A taken jump redirects the PC, and any read already in flight when the
// redirect arrives is marked stale so that its response is discarded.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   imem_req_valid   read request valid (registered)
//   imem_req_addr    read address, always the current pc
//   imem_req_ready   memory accepts the request this cycle
//   imem_rsp_valid   read data valid, one per accepted request
//   imem_rsp_data    read data
//   inst_valid       inst holds a word for the decoder
//   inst             instruction word presented to the decoder
//   inst_pc          address the word in inst came from
//   inst_ready       execute consumes inst this cycle
//   jmp_taken        redirect request from execute
//   jmp_target       redirect address, sampled with jmp_taken
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [15:0]       imem_rsp_data,
  output logic              inst_valid,
  output logic [15:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              jmp_taken,
  input  logic [ADDR_W-1:0] jmp_target
);

  typedef logic [15:0] inst_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] pc_r;
  logic              drop_r;
  logic              req_valid_r;
  logic              inst_valid_r;
  inst_word_t        inst_r;
  logic [ADDR_W-1:0] inst_pc_r;

  // The request address is simply the pc register, so it only moves while
  // valid when a redirect lands in REQ.
  assign imem_req_valid = req_valid_r;
  assign imem_req_addr  = pc_r;
  assign inst_valid     = inst_valid_r;
  assign inst           = inst_r;
  assign inst_pc        = inst_pc_r;

  // Fetch FSM: pc, stale-response flag and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      pc_r         <= RESET_PC;
      drop_r       <= 1'b0;
      req_valid_r  <= 1'b0;
      inst_valid_r <= 1'b0;
      inst_r       <= 16'h0000;
      inst_pc_r    <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (jmp_taken) begin
            pc_r <= jmp_target;
          end
          state_r     <= REQ;
          req_valid_r <= 1'b1;
        end

        REQ: begin
          if (jmp_taken) begin
            pc_r <= jmp_target;
            if (imem_req_ready) begin
              // The old address was accepted this cycle; its data is stale.
              drop_r      <= 1'b1;
              state_r     <= WAIT;
              req_valid_r <= 1'b0;
            end
          end else if (imem_req_ready) begin
            state_r     <= WAIT;
            req_valid_r <= 1'b0;
          end
        end

        WAIT: begin
          if (jmp_taken) begin
            pc_r <= jmp_target;
            if (imem_rsp_valid) begin
              // The outstanding read completes now, so nothing is left to drop.
              drop_r      <= 1'b0;
              state_r     <= REQ;
              req_valid_r <= 1'b1;
            end else begin
              drop_r <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (drop_r) begin
              drop_r      <= 1'b0;
              state_r     <= REQ;
              req_valid_r <= 1'b1;
            end else begin
              inst_r       <= imem_rsp_data;
              inst_pc_r    <= pc_r;
              inst_valid_r <= 1'b1;
              state_r      <= HOLD;
            end
          end
        end

        HOLD: begin
          if (jmp_taken) begin
            pc_r         <= jmp_target;
            inst_valid_r <= 1'b0;
            state_r      <= REQ;
            req_valid_r  <= 1'b1;
          end else if (inst_ready) begin
            // Natural wrap at 2^ADDR_W.
            pc_r         <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            inst_valid_r <= 1'b0;
            state_r      <= REQ;
            req_valid_r  <= 1'b1;
          end
        end

        default: begin
          state_r      <= IDLE;
          drop_r       <= 1'b0;
          req_valid_r  <= 1'b0;
          inst_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch: scoreboard bench for inst_fetch.
// Stimulus pushes expected request addresses and expected (pc, word) pairs;
// a negedge environment process models instruction memory and execute, and
// pops/compares whenever the DUT issues a request or hands over a word.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [15:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_ready;
  logic        jmp_taken;
  logic [15:0] jmp_target;

  inst_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .jmp_taken      (jmp_taken),
    .jmp_target     (jmp_target)
  );

  typedef struct {
    logic [15:0] pc;
    logic [15:0] word;
  } exp_inst_t;

  logic [15:0] exp_req[$];
  exp_inst_t   exp_inst[$];

  int checks;
  int failures;

  // Environment knobs set by stimulus
  int   mem_lat;
  logic mem_ready_en;
  logic cons_en;
  logic chk_period;

  // Environment state
  int          cyc;
  logic        mem_pending;
  int          mem_cnt;
  logic [15:0] mem_addr;
  int          acc_cnt;
  logic [15:0] last_acc;
  logic        held;
  logic [15:0] held_inst;
  logic [15:0] held_pc;
  int          last_pop_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h8010;
      16'h0001: return 16'h0005;
      16'h0002: return 16'hFC10;
      16'h0003: return 16'h0007;
      default:  return a ^ 16'h5A5A;
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory model, execute model and the two scoreboard monitors.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mem_pending    = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b0;
      inst_ready     = 1'b0;
      held           = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      if (mem_pending) begin
        if (mem_cnt <= 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(mem_addr);
          mem_pending    = 1'b0;
        end else begin
          mem_cnt--;
        end
      end

      if (imem_req_valid) check("single_outstanding", {15'h0000, mem_pending}, 16'h0000);

      imem_req_ready = mem_ready_en && (exp_req.size() > 0);
      if (imem_req_valid && imem_req_ready) begin
        logic [15:0] e;
        e = exp_req.pop_front();
        check("req_addr", imem_req_addr, e);
        mem_pending = 1'b1;
        mem_cnt     = mem_lat;
        mem_addr    = imem_req_addr;
        acc_cnt++;
        last_acc    = imem_req_addr;
      end

      inst_ready = cons_en && (exp_inst.size() > 0);
      if (!chk_period) last_pop_cyc = -1;
      if (inst_valid) begin
        if (held) begin
          check("inst_stable", inst, held_inst);
          check("inst_pc_stable", inst_pc, held_pc);
        end
        if (exp_inst.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_inst actual=%h at pc=%h expected=none", inst, inst_pc);
        end
        if (inst_ready) begin
          exp_inst_t x;
          x = exp_inst.pop_front();
          check("inst_word", inst, x.word);
          check("inst_pc", inst_pc, x.pc);
          if (chk_period && last_pop_cyc >= 0)
            check("fetch_period", 16'(cyc - last_pop_cyc), 16'd3);
          last_pop_cyc = cyc;
          held = 1'b0;
        end else begin
          held      = 1'b1;
          held_inst = inst;
          held_pc   = inst_pc;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic push_inst(input logic [15:0] pc, input logic [15:0] word);
    exp_inst_t x;
    x.pc   = pc;
    x.word = word;
    exp_inst.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Redirect while the DUT sits in REQ with memory stalled.
  task automatic redirect(input logic [15:0] tgt);
    jmp_taken  = 1'b1;
    jmp_target = tgt;
    tick();
    jmp_taken  = 1'b0;
    check("redirect_addr", imem_req_addr, tgt);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_req.size() != 0 || exp_inst.size() != 0 || mem_pending) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL drain_%s actual=timeout req_left=%0d inst_left=%0d expected=empty",
               name, exp_req.size(), exp_inst.size());
      exp_req.delete();
      exp_inst.delete();
    end
    tick();
  endtask

  task automatic wait_acc(input logic [15:0] addr);
    int start;
    int n;
    start = acc_cnt;
    n = 0;
    while (!(acc_cnt != start && last_acc == addr) && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL wait_acc actual=timeout expected=accept of %h", addr);
    end
  endtask

  task automatic wait_inst_valid();
    int n;
    n = 0;
    while (!inst_valid && n < 100) begin
      tick();
      n++;
    end
    check("inst_valid_arrives", {15'h0000, inst_valid}, 16'h0001);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    cyc          = 0;
    acc_cnt      = 0;
    last_acc     = 16'h0000;
    mem_pending  = 1'b0;
    mem_cnt      = 0;
    held         = 1'b0;
    last_pop_cyc = -1;
    mem_lat      = 1;
    mem_ready_en = 1'b1;
    cons_en      = 1'b1;
    chk_period   = 1'b0;
    rst          = 1'b1;
    jmp_taken    = 1'b0;
    jmp_target   = 16'h0000;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 16'h0000;
    inst_ready     = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_req_valid", {15'h0000, imem_req_valid}, 16'h0000);
    check("rst_req_addr", imem_req_addr, 16'h0000);
    check("rst_inst_valid", {15'h0000, inst_valid}, 16'h0000);
    check("rst_inst", inst, 16'h0000);
    check("rst_inst_pc", inst_pc, 16'h0000);

    // Sequential fetch, zero-wait memory, 3 cycles per instruction
    exp_req.push_back(16'h0000);
    exp_req.push_back(16'h0001);
    exp_req.push_back(16'h0002);
    exp_req.push_back(16'h0003);
    push_inst(16'h0000, 16'h8010);
    push_inst(16'h0001, 16'h0005);
    push_inst(16'h0002, 16'hFC10);
    push_inst(16'h0003, 16'h0007);
    chk_period = 1'b1;
    rst = 1'b0;
    tick();
    check("idle_to_req", {15'h0000, imem_req_valid}, 16'h0001);
    drain("seq");
    chk_period = 1'b0;

    // 3-cycle memory, decoder stalls 5 cycles
    mem_lat = 3;
    cons_en = 1'b0;
    redirect(16'h0000);
    exp_req.push_back(16'h0000);
    push_inst(16'h0000, 16'h8010);
    wait_inst_valid();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", {15'h0000, inst_valid}, 16'h0001);
      check("hold_inst", inst, 16'h8010);
      check("hold_no_req", {15'h0000, imem_req_valid}, 16'h0000);
    end
    cons_en = 1'b1;
    drain("stall");

    // Redirect during WAIT for address 2: its response is dropped
    redirect(16'h0002);
    exp_req.push_back(16'h0002);
    exp_req.push_back(16'h0040);
    push_inst(16'h0040, 16'h5A1A);
    wait_acc(16'h0002);
    jmp_taken  = 1'b1;
    jmp_target = 16'h0040;
    tick();
    jmp_taken  = 1'b0;
    drain("wait_jmp");

    // Redirect together with inst_ready in HOLD at pc=5
    mem_lat = 1;
    cons_en = 1'b0;
    redirect(16'h0005);
    exp_req.push_back(16'h0005);
    exp_req.push_back(16'h0010);
    push_inst(16'h0005, 16'h5A5F);
    push_inst(16'h0010, 16'h5A4A);
    wait_inst_valid();
    cons_en    = 1'b1;
    jmp_taken  = 1'b1;
    jmp_target = 16'h0010;
    tick();
    jmp_taken  = 1'b0;
    drain("hold_jmp");

    // Redirect in the same cycle as the response in WAIT
    mem_lat = 2;
    redirect(16'h0020);
    exp_req.push_back(16'h0020);
    exp_req.push_back(16'h0030);
    push_inst(16'h0030, 16'h5A6A);
    wait_acc(16'h0020);
    tick();
    jmp_taken  = 1'b1;
    jmp_target = 16'h0030;
    tick();
    jmp_taken  = 1'b0;
    check("same_cycle_req_valid", {15'h0000, imem_req_valid}, 16'h0001);
    check("same_cycle_req_addr", imem_req_addr, 16'h0030);
    drain("rsp_jmp");

    // PC wrap from 16'hFFFF, then reset while waiting on address 0
    mem_lat = 4;
    redirect(16'hFFFF);
    exp_req.push_back(16'hFFFF);
    exp_req.push_back(16'h0000);
    push_inst(16'hFFFF, 16'hA5A5);
    wait_acc(16'h0000);
    check("wrap_inst_pc_before_rst", inst_pc, 16'hFFFF);
    rst = 1'b1;
    #1;
    check("midrst_req_valid", {15'h0000, imem_req_valid}, 16'h0000);
    check("midrst_inst_valid", {15'h0000, inst_valid}, 16'h0000);
    check("midrst_inst", inst, 16'h0000);
    check("midrst_inst_pc", inst_pc, 16'h0000);
    check("midrst_req_addr", imem_req_addr, 16'h0000);
    tick();
    tick();
    mem_lat = 1;
    exp_req.push_back(16'h0000);
    push_inst(16'h0000, 16'h8010);
    rst = 1'b0;
    drain("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
